bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
Direct-mapped branch history table that drives the IF stage's prediction redirect (pc_ld_bht / bht_pc_new).
- Lookup: combinational on the current fetch PC.
- Update: from the resolving stage, with the actual outcome and target of each branch.
- Also keeps saturating counters of predicted-taken lookups and mispredictions, read by the debug/stat display.

Parameters:
ADDR_NBIT, 10, width of fetch and target addresses (byte addresses; bits [1:0] ignored).
IDX_NBIT, 3, index width; table holds 2**IDX_NBIT entries.
STAT_NBIT, 32, width of statistic counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  pipeline advance; gates statistics and lookup output
clr  in  1  synchronous invalidate of all entries; statistics kept
pc  in  ADDR_NBIT  current fetch PC
pc_ld_bht  out  1  predict taken; IF loads bht_pc_new
bht_pc_new  out  ADDR_NBIT  predicted target
pred_hit  out  1  lookup hit a valid tagged entry; carried down the pipe
upd_en  in  1  a branch resolved this cycle
upd_pc  in  ADDR_NBIT  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  ADDR_NBIT  actual taken target
upd_pred_taken  in  1  prediction that was made for this branch
stat_pred  out  STAT_NBIT  number of predicted-taken lookups
stat_miss  out  STAT_NBIT  number of mispredictions

Behaviour:
Decided: one clock, clk; reset rst is synchronous and active-high.

Address split:
- idx = addr[IDX_NBIT+1:2]; tag = addr[ADDR_NBIT-1:IDX_NBIT+2].
- Each entry holds: valid, tag, target, 2-bit counter (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T).

Reset:
- All valid bits 0 and both stat counters 0, so pc_ld_bht=0, pred_hit=0, bht_pc_new=0 after reset.
- Tag, target and counter contents are don't-care when valid=0.
- rst has priority over clr and upd_en.

Lookup (combinational, zero latency):
- hit = valid[idx] && tag[idx]==tag(pc).
- pred_hit = en && hit.
- pc_ld_bht = en && hit && ctr[idx][1].
- bht_pc_new = target[idx] when pc_ld_bht, else 0.

Update (at posedge when upd_en and not rst/clr):
- Update hit (valid and tag match at idx(upd_pc)):
  - ctr saturating +1 if upd_taken, -1 otherwise; 3 stays 3, 0 stays 0.
  - If upd_taken, target <= upd_target.
- Update miss and upd_taken: allocate, overwriting the old entry. valid=1, tag, target=upd_target, ctr=2.
- Update miss and not taken: no change.

Ordering and boundary cases:
- Same-cycle lookup and update to the same idx: the lookup sees pre-update contents; no bypass.
- clr together with upd_en: clr wins and the update is dropped.
- Changing en does not affect table updates.
- A mid-operation rst discards everything in the same cycle.

Statistics (on the same edge):
- stat_pred += 1 when pc_ld_bht.
- stat_miss += 1 when upd_en && upd_pred_taken != upd_taken.
- Both saturate at all-ones; they do not wrap.

Decomposition:
- Core.vh: IM_ADDR_NBIT (the default for ADDR_NBIT) and the counter encodings CTR_SNT/WNT/WT/ST.
- One sub-module, sat_ctr2: the 2-bit saturating counter next-state function.
- Table arrays and the stat counters are inline.

Test Plan:
1. Reset, then pc=0x040 -> pc_ld_bht=0, pred_hit=0, stat_pred=0, stat_miss=0.
2. upd_en, upd_pc=0x040, taken, target=0x100, pred_taken=0; next cycle pc=0x040 -> pc_ld_bht=1, bht_pc_new=0x100, stat_miss=1; pc=0x060 (same idx, other tag) -> pred_hit=0.
3. From ctr=2, two not-taken updates at 0x040 -> ctr 1 then 0; lookup shows pred_hit=1, pc_ld_bht=0. A third not-taken update leaves ctr at 0. Two taken updates -> pc_ld_bht=1.
4. upd_pc=0x044 not taken on an empty entry -> no allocation; lookup 0x044 gives pred_hit=0.
5. Lookup pc=0x040 with an update to 0x040 in the same cycle -> output reflects old state; new state is visible next cycle. en=0 -> pc_ld_bht=0 and stat_pred unchanged.
6. Assert clr with upd_en -> all lookups miss and the update is dropped; stat values are preserved. Preload stat_miss near all-ones, then mispredict -> stays all-ones.

Source files
------------

// File: rtl/bht_predictor_pkg.sv
// Shared constants for the branch history table: default address width and
// the 2-bit saturating counter encodings.
package bht_predictor_pkg;

    localparam int IM_ADDR_NBIT = 10;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,  // strong not-taken
        CTR_WNT = 2'd1,  // weak not-taken
        CTR_WT  = 2'd2,  // weak taken
        CTR_ST  = 2'd3   // strong taken
    } ctr_e;

endpackage

// File: rtl/bht_predictor_sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_ctr2
    import bht_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    // Step toward taken on inc, toward not-taken otherwise; clamp at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table: zero-latency lookup on the fetch PC,
// update from the resolving stage, plus saturating prediction/miss counters.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int ADDR_NBIT = IM_ADDR_NBIT,
    parameter int IDX_NBIT  = 3,
    parameter int STAT_NBIT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [ADDR_NBIT-1:0] pc,
    output logic                 pc_ld_bht,
    output logic [ADDR_NBIT-1:0] bht_pc_new,
    output logic                 pred_hit,
    input  logic                 upd_en,
    input  logic [ADDR_NBIT-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [ADDR_NBIT-1:0] upd_target,
    input  logic                 upd_pred_taken,
    output logic [STAT_NBIT-1:0] stat_pred,
    output logic [STAT_NBIT-1:0] stat_miss
);

    localparam int NENT     = 1 << IDX_NBIT;
    localparam int TAG_NBIT = ADDR_NBIT - IDX_NBIT - 2;

    // Table storage; only valid is reset, the rest is meaningless while invalid.
    logic [NENT-1:0]                valid_q, valid_d;
    logic [NENT-1:0][TAG_NBIT-1:0]  tag_q;
    logic [NENT-1:0][ADDR_NBIT-1:0] tgt_q;
    logic [NENT-1:0][1:0]           ctr_q;

    logic [STAT_NBIT-1:0] stat_pred_q, stat_pred_d;
    logic [STAT_NBIT-1:0] stat_miss_q, stat_miss_d;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_offs;
    assign unused_offs = ^{pc[1:0], upd_pc[1:0]};

    // Lookup path
    logic [IDX_NBIT-1:0] lk_idx;
    logic [TAG_NBIT-1:0] lk_tag;
    logic                lk_hit;

    assign lk_idx = pc[IDX_NBIT+1:2];
    assign lk_tag = pc[ADDR_NBIT-1:IDX_NBIT+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign pred_hit   = en && lk_hit;
    assign pc_ld_bht  = en && lk_hit && ctr_q[lk_idx][1];
    assign bht_pc_new = pc_ld_bht ? tgt_q[lk_idx] : '0;

    // Update path
    logic [IDX_NBIT-1:0] up_idx;
    logic [TAG_NBIT-1:0] up_tag;
    logic                up_hit;
    logic                up_we;
    logic [1:0]          up_ctr_nxt;

    assign up_idx = upd_pc[IDX_NBIT+1:2];
    assign up_tag = upd_pc[ADDR_NBIT-1:IDX_NBIT+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    // An entry is written on a hit (counter move) or a taken miss (allocate).
    assign up_we  = upd_en && !rst && !clr && (up_hit || upd_taken);

    sat_ctr2 u_ctr (
        .ctr_i (ctr_q[up_idx]),
        .inc_i (upd_taken),
        .ctr_o (up_ctr_nxt)
    );

    // Valid bits: clr invalidates everything and swallows a concurrent update.
    always_comb begin
        valid_d = valid_q;
        if (clr) valid_d = '0;
        else if (upd_en && upd_taken) valid_d[up_idx] = 1'b1;
    end

    // Valid register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Payload write: allocation starts at weak-taken, hits step the counter.
    always_ff @(posedge clk) begin
        if (up_we) begin
            ctr_q[up_idx] <= up_hit ? up_ctr_nxt : CTR_WT;
            if (upd_taken) begin
                tag_q[up_idx] <= up_tag;
                tgt_q[up_idx] <= upd_target;
            end
        end
    end

    // Statistics next state: count events, hold at all-ones instead of wrapping.
    always_comb begin
        stat_pred_d = stat_pred_q;
        stat_miss_d = stat_miss_q;
        if (pc_ld_bht && !(&stat_pred_q))
            stat_pred_d = stat_pred_q + STAT_NBIT'(1);
        if (upd_en && (upd_pred_taken != upd_taken) && !(&stat_miss_q))
            stat_miss_d = stat_miss_q + STAT_NBIT'(1);
    end

    // Statistics registers; clr leaves them alone, only rst zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pred_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_pred_q <= stat_pred_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_pred = stat_pred_q;
    assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed plus random stimulus against a behavioural table model.
module tb_bht_predictor;

    localparam int AW   = 10;
    localparam int SW   = 5;
    localparam int SMAX = (1 << SW) - 1;
    localparam int NE   = 8;

    logic          clk = 1'b0;
    logic          rst, en, clr, upd_en, upd_taken, upd_pred_taken;
    logic [AW-1:0] pc, upd_pc, upd_target;
    logic          pc_ld_bht, pred_hit;
    logic [AW-1:0] bht_pc_new;
    logic [SW-1:0] stat_pred, stat_miss;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 1'b0;

    // Model state: entry = {valid, tag, target, counter as a plain integer 0..3}
    bit m_valid [NE];
    int m_tag   [NE];
    int m_tgt   [NE];
    int m_ctr   [NE];
    int m_pred, m_miss;

    always #5 clk = ~clk;

    bht_predictor #(.ADDR_NBIT(AW), .IDX_NBIT(3), .STAT_NBIT(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .clr            (clr),
        .pc             (pc),
        .pc_ld_bht      (pc_ld_bht),
        .bht_pc_new     (bht_pc_new),
        .pred_hit       (pred_hit),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .stat_pred      (stat_pred),
        .stat_miss      (stat_miss)
    );

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int midx(input int a); return (a / 4) % NE; endfunction
    function automatic int mtag(input int a); return a / (4 * NE); endfunction

    function automatic bit m_hit(input int a);
        return m_valid[midx(a)] && (m_tag[midx(a)] == mtag(a));
    endfunction

    // Model-driven check of every output for the current inputs.
    task automatic check_all();
        bit h, ld;
        h  = en && m_hit(int'(pc));
        ld = h && (m_ctr[midx(int'(pc))] >= 2);
        cmp("pred_hit",   int'(pred_hit),   int'(h));
        cmp("pc_ld_bht",  int'(pc_ld_bht),  int'(ld));
        cmp("bht_pc_new", int'(bht_pc_new), ld ? m_tgt[midx(int'(pc))] : 0);
        cmp("stat_pred",  int'(stat_pred),  m_pred);
        cmp("stat_miss",  int'(stat_miss),  m_miss);
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        int i;
        bit ld;
        if (rst) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_pred = 0;
            m_miss = 0;
            return;
        end
        ld = en && m_hit(int'(pc)) && (m_ctr[midx(int'(pc))] >= 2);
        if (ld && m_pred < SMAX) m_pred++;
        if (upd_en && (upd_pred_taken != upd_taken) && m_miss < SMAX) m_miss++;
        if (clr) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
        end else if (upd_en) begin
            i = midx(int'(upd_pc));
            if (m_hit(int'(upd_pc))) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = int'(upd_target);
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = mtag(int'(upd_pc));
                m_tgt[i]   = int'(upd_target);
                m_ctr[i]   = 2;
            end
        end
    endtask

    // Compare process: check mid-cycle, step the model at the edge.
    initial begin
        m_pred = 0;
        m_miss = 0;
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (chk_on) check_all();
            @(posedge clk);
            model_step();
        end
    end

    task automatic drv(input bit e, input bit c, input int p, input bit ue, input int up,
                       input bit tk, input int tg, input bit pt);
        @(negedge clk);
        en = e; clr = c; pc = AW'(p);
        upd_en = ue; upd_pc = AW'(up); upd_taken = tk; upd_target = AW'(tg); upd_pred_taken = pt;
        #3;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("rst_ld", int'(pc_ld_bht), 0);
        cmp("rst_hit", int'(pred_hit), 0);
        cmp("rst_spred", int'(stat_pred), 0);
        cmp("rst_smiss", int'(stat_miss), 0);

        // Allocate on taken miss; same-cycle lookup sees the old contents
        drv(1, 0, 'h040, 1, 'h040, 1, 'h100, 0);
        cmp("alloc_nobypass_hit", int'(pred_hit), 0);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("alloc_ld", int'(pc_ld_bht), 1);
        cmp("alloc_tgt", int'(bht_pc_new), 'h100);
        cmp("alloc_smiss", int'(stat_miss), 1);
        drv(1, 0, 'h060, 0, 0, 0, 0, 0);
        cmp("tag_mismatch_hit", int'(pred_hit), 0);

        // Counter walks down and saturates at 0, then back up
        drv(1, 0, 'h060, 1, 'h040, 0, 0, 0);
        drv(1, 0, 'h060, 1, 'h040, 0, 0, 0);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("ctr0_hit", int'(pred_hit), 1);
        cmp("ctr0_ld", int'(pc_ld_bht), 0);
        drv(1, 0, 'h060, 1, 'h040, 0, 0, 0);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("ctr0_sat_ld", int'(pc_ld_bht), 0);
        drv(1, 0, 'h060, 1, 'h040, 1, 'h100, 1);
        drv(1, 0, 'h060, 1, 'h040, 1, 'h100, 1);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("ctr2_ld", int'(pc_ld_bht), 1);

        // Not-taken miss must not allocate
        drv(1, 0, 'h060, 1, 'h044, 0, 0, 0);
        drv(1, 0, 'h044, 0, 0, 0, 0, 0);
        cmp("nt_noalloc_hit", int'(pred_hit), 0);

        // Same-cycle update is not bypassed
        drv(1, 0, 'h040, 1, 'h040, 0, 0, 1);
        cmp("same_cyc_old_ld", int'(pc_ld_bht), 1);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("same_cyc_new_ld", int'(pc_ld_bht), 0);
        cmp("same_cyc_new_hit", int'(pred_hit), 1);
        drv(1, 0, 'h060, 1, 'h040, 1, 'h180, 1);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("retarget", int'(bht_pc_new), 'h180);

        // en low gates outputs and stat_pred
        drv(0, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("en0_ld", int'(pc_ld_bht), 0);
        cmp("en0_tgt", int'(bht_pc_new), 0);
        drv(0, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("en0_spred", int'(stat_pred), 4);

        // clr beats a concurrent update; stats survive
        drv(1, 1, 'h040, 1, 'h044, 1, 'h200, 1);
        drv(1, 0, 'h040, 0, 0, 0, 0, 0);
        cmp("clr_hit040", int'(pred_hit), 0);
        drv(1, 0, 'h044, 0, 0, 0, 0, 0);
        cmp("clr_drop_hit044", int'(pred_hit), 0);
        cmp("clr_spred", int'(stat_pred), 5);
        cmp("clr_smiss", int'(stat_miss), 2);

        // Miss counter saturates
        repeat (SMAX + 4) drv(1, 0, 'h060, 1, 'h060, 0, 0, 1);
        drv(1, 0, 'h060, 0, 0, 0, 0, 0);
        cmp("smiss_sat", int'(stat_miss), SMAX);

        // Random traffic over a small address space so hits are frequent
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 199) == 0);
            clr            = ($urandom_range(0, 99) == 0);
            en             = ($urandom_range(0, 99) < 85);
            pc             = AW'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            upd_en         = ($urandom_range(0, 99) < 60);
            upd_pc         = AW'($urandom_range(0, 63) * 4);
            upd_taken      = 1'($urandom_range(0, 1));
            upd_target     = AW'($urandom_range(0, (1 << AW) - 1));
            upd_pred_taken = clr ? upd_taken : 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        rst = 1'b0; clr = 1'b0; upd_en = 1'b0;
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
